sprite_compositor: RTL and testbench
====================================

Name: sprite_compositor

Overview:
- Parametrised object-layer compositor for the surfing display pipeline. It replaces the fixed single-collectable priority mux.
- Holds a table of N_OBJ object descriptors, latched once per frame. Finds the highest-priority object under the current pixel and drives a shared sprite-ROM lookup.
- Composites character, object and background pixels into p_rgb.
- Accumulates per-object character-collision flags and reports them to game logic once per frame.

Parameters:
- N_OBJ, 5, number of object slots; slot 0 has highest priority.
- OBJ_W, 15, object sprite width in pixels.
- OBJ_H, 16, object sprite height in pixels.
- LOG_FRAMES, 3, animation frame index width.
- TRANSPARENT, 12'h000, ROM/sprite colour treated as see-through.
- DEFAULT_RGB, 12'hF0F, colour when no layer supplies a pixel.

Ports:
- vclock  in  1  65 MHz pixel clock.
- reset  in  1  synchronous, active-high reset.
- hcount  in  11  current pixel column, 0 at left.
- vcount  in  10  current pixel row, 0 at top.
- hsync  in  1  active low.
- vsync  in  1  active low.
- blank  in  1  active high.
- obj_table  in  N_OBJ*26  packed descriptors, slot i at [26i+25:26i]. Per descriptor: 25:23 frame, 22:21 type, 20:10 x, 9:0 y. All-zero means slot disabled.
- char_rgb  in  12  character sprite pixel, registered 1 cycle after hcount/vcount.
- bg_rgb  in  12  background pixel, registered 1 cycle after hcount/vcount. 0 means none.
- rom_x  out  4  column within the winning sprite; 0 when no winner.
- rom_y  out  4  row within the winning sprite; 0 when no winner.
- rom_type  out  2  type of the winning object.
- rom_frame  out  LOG_FRAMES  frame of the winning object.
- rom_pixel  in  12  combinational ROM data for the rom_* address.
- p_rgb  out  12  composited pixel.
- hsync_out, vsync_out, blank_out  out  1 each  input syncs delayed to align with p_rgb.
- coll_flags  out  N_OBJ  bit i set if object i touched the character during the previous frame.
- coll_valid  out  1  one-cycle pulse when coll_flags updates.

Behaviour:
- All state is clocked on posedge vclock. Reset is synchronous: reset has priority over every other event in the same cycle.
- Reset values:
  - p_rgb = 0; coll_flags = 0; coll_valid = 0; coll_acc = 0.
  - Table registers = 0, so all slots are disabled.
  - hsync_out = 1, vsync_out = 1, blank_out = 1.
  - vsync_d = 1; all pipeline valid bits = 0.
- Frame edge: frame_edge = vsync_d & ~vsync, where vsync_d is the previous-cycle vsync.
- On frame_edge, all of the following happen in the same cycle:
  - The table is loaded from obj_table.
  - coll_flags <= coll_acc OR any hit being recorded this cycle.
  - coll_acc <= 0.
  - coll_valid <= 1.
- coll_valid is 0 in every other cycle.
- Stage 1 (edge after hcount/vcount presented):
  - For each enabled slot i, hit[i] = (hcount >= x_i) & (hcount < x_i+OBJ_W) & (vcount >= y_i) & (vcount < y_i+OBJ_H).
  - Horizontal sums are computed in 12 bits and vertical sums in 11 bits, so an object near the right or bottom edge never wraps.
  - Register win_valid = |hit and win_idx = lowest set index.
  - Register rel_x = hcount-x, rel_y = vcount-y, type and frame of the winner.
- ROM: rom_* outputs come directly from the stage-1 registers. rom_pixel is returned in the same cycle.
- Stage 2 selection, in priority order:
  1. char_rgb != 0 → char_rgb.
  2. win_valid & rom_pixel != TRANSPARENT → rom_pixel.
  3. bg_rgb != 0 → bg_rgb.
  4. Otherwise DEFAULT_RGB.
- A transparent ROM pixel of the winning object does NOT fall through to lower-priority objects. Only one ROM lookup is made per pixel.
- Latency: hcount/vcount at edge t → p_rgb valid after edge t+2. hsync/vsync/blank pass through a 2-stage delay to match.
- Blank handling: when blank is high at stage 2 (the delayed copy), p_rgb = 0 regardless of layers.
- Collision: in stage 2, if char_rgb != 0 & win_valid & rom_pixel != TRANSPARENT & ~blank(delayed), then coll_acc[win_idx] <= 1.
- Collision fields are sticky within a frame. A hit coincident with frame_edge is reported in the frame closing on that edge, not lost.
- Table changes take effect only at frame_edge. Mid-frame obj_table changes are ignored.
- Reset mid-frame clears coll_acc, and the next frame_edge reports 0 flags.

Test Plan:
- Reset, then vsync falling with obj_table slot0 = {frame 2, type 0, x 100, y 200}: at hcount 100, vcount 200, rom_x/rom_y = 0/0, rom_frame = 2 one cycle later; p_rgb = rom_pixel 2 cycles later. At hcount 115, win_valid = 0.
- Slot0 and slot3 overlap at (300,300), ROM returns TRANSPARENT for slot0 → p_rgb = bg_rgb (0x00F). Slot3 is not shown. rom_type is the slot0 type.
- Change obj_table mid-frame → rendering is unchanged until the next vsync falling edge, then uses the new positions.
- char_rgb = 0xFA0 coincident with slot2 opaque pixel → p_rgb = 0xFA0. At the next frame_edge, coll_flags = 5'b00100 with a single-cycle coll_valid. The following frame with no overlap → coll_flags = 0.
- Object at x = 2040, y = 1020 → no hit anywhere on the 1024×768 visible area and no wrap to the left or top.
- Assert reset during active video after a collision → p_rgb = 0 and coll_acc cleared; the next frame_edge gives coll_flags = 0. hsync_out/vsync_out track the inputs delayed by exactly 2 cycles after reset.

Source files
------------

// File: rtl/sprite_compositor_if.sv
// Pixel-stream, object-table, sprite-ROM and composited-output bundle for sprite_compositor.
`default_nettype none

interface sprite_compositor_if #(
  parameter int N_OBJ      = 5,
  parameter int LOG_FRAMES = 3
);
  logic [10:0]           hcount;
  logic [9:0]            vcount;
  logic                  hsync;
  logic                  vsync;
  logic                  blank;
  logic [N_OBJ*26-1:0]   obj_table;
  logic [11:0]           char_rgb;
  logic [11:0]           bg_rgb;
  logic [3:0]            rom_x;
  logic [3:0]            rom_y;
  logic [1:0]            rom_type;
  logic [LOG_FRAMES-1:0] rom_frame;
  logic [11:0]           rom_pixel;
  logic [11:0]           p_rgb;
  logic                  hsync_out;
  logic                  vsync_out;
  logic                  blank_out;
  logic [N_OBJ-1:0]      coll_flags;
  logic                  coll_valid;

  modport master (
    output hcount, vcount, hsync, vsync, blank, obj_table, char_rgb, bg_rgb, rom_pixel,
    input  rom_x, rom_y, rom_type, rom_frame, p_rgb, hsync_out, vsync_out, blank_out,
           coll_flags, coll_valid
  );

  modport slave (
    input  hcount, vcount, hsync, vsync, blank, obj_table, char_rgb, bg_rgb, rom_pixel,
    output rom_x, rom_y, rom_type, rom_frame, p_rgb, hsync_out, vsync_out, blank_out,
           coll_flags, coll_valid
  );
endinterface

`default_nettype wire

// File: rtl/sprite_compositor.sv
// sprite_compositor: per-frame object table, priority hit search, shared sprite-ROM lookup,
// 3-layer pixel compositing and per-frame character collision reporting.
`default_nettype none

module sprite_compositor #(
  parameter int          N_OBJ       = 5,
  parameter int          OBJ_W       = 15,
  parameter int          OBJ_H       = 16,
  parameter int          LOG_FRAMES  = 3,
  parameter logic [11:0] TRANSPARENT = 12'h000,
  parameter logic [11:0] DEFAULT_RGB = 12'hF0F
) (
  input  logic vclock,
  input  logic reset,
  sprite_compositor_if.slave bus
);
  localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

  logic [N_OBJ*26-1:0]   table_q;
  logic                  vsync_d;
  logic                  frame_edge;
  logic [N_OBJ-1:0]      hit;
  logic                  any_hit;
  logic [IDX_W-1:0]      sel_idx;
  logic [3:0]            rel_x_c;
  logic [3:0]            rel_y_c;
  logic [1:0]            type_c;
  logic [LOG_FRAMES-1:0] frame_c;

  logic                  win_valid;
  logic [IDX_W-1:0]      win_idx;
  logic [3:0]            rel_x;
  logic [3:0]            rel_y;
  logic [1:0]            win_type;
  logic [LOG_FRAMES-1:0] win_frame;
  logic                  hsync_d1;
  logic                  vsync_d1;
  logic                  blank_d1;

  logic                  rom_opaque;
  logic                  coll_hit;
  logic [N_OBJ-1:0]      coll_new;
  logic [N_OBJ-1:0]      coll_acc;

  assign frame_edge = vsync_d & ~bus.vsync;

  // Bounds are widened by one bit so objects near the right/bottom edge cannot wrap.
  for (genvar i = 0; i < N_OBJ; i++) begin : g_slot
    logic [25:0] desc;
    logic [11:0] x_lo;
    logic [11:0] x_hi;
    logic [10:0] y_lo;
    logic [10:0] y_hi;
    assign desc = table_q[26*i +: 26];
    assign x_lo = {1'b0, desc[20:10]};
    assign x_hi = x_lo + 12'(OBJ_W);
    assign y_lo = {1'b0, desc[9:0]};
    assign y_hi = y_lo + 11'(OBJ_H);
    assign hit[i] = (|desc)
                  && ({1'b0, bus.hcount} >= x_lo) && ({1'b0, bus.hcount} < x_hi)
                  && ({1'b0, bus.vcount} >= y_lo) && ({1'b0, bus.vcount} < y_hi);
  end

  always_comb begin
    any_hit = |hit;
    sel_idx = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hit[i]) sel_idx = IDX_W'(i);
    end
    rel_x_c = '0;
    rel_y_c = '0;
    type_c  = '0;
    frame_c = '0;
    if (any_hit) begin
      rel_x_c = bus.hcount[3:0] - table_q[26*sel_idx + 10 +: 4];
      rel_y_c = bus.vcount[3:0] - table_q[26*sel_idx +: 4];
      type_c  = table_q[26*sel_idx + 21 +: 2];
      frame_c = table_q[26*sel_idx + 23 +: LOG_FRAMES];
    end
  end

  assign bus.rom_x     = rel_x;
  assign bus.rom_y     = rel_y;
  assign bus.rom_type  = win_type;
  assign bus.rom_frame = win_frame;

  assign rom_opaque = win_valid && (bus.rom_pixel != TRANSPARENT);
  assign coll_hit   = (bus.char_rgb != 12'h000) && rom_opaque && !blank_d1;
  assign coll_new   = coll_hit ? (N_OBJ'(1) << win_idx) : '0;

  always_ff @(posedge vclock) begin
    if (reset) begin
      table_q        <= '0;
      vsync_d        <= 1'b1;
      win_valid      <= 1'b0;
      win_idx        <= '0;
      rel_x          <= '0;
      rel_y          <= '0;
      win_type       <= '0;
      win_frame      <= '0;
      hsync_d1       <= 1'b1;
      vsync_d1       <= 1'b1;
      blank_d1       <= 1'b1;
      bus.p_rgb      <= '0;
      bus.hsync_out  <= 1'b1;
      bus.vsync_out  <= 1'b1;
      bus.blank_out  <= 1'b1;
      coll_acc       <= '0;
      bus.coll_flags <= '0;
      bus.coll_valid <= 1'b0;
    end else begin
      vsync_d   <= bus.vsync;
      if (frame_edge) table_q <= bus.obj_table;

      win_valid <= any_hit;
      win_idx   <= sel_idx;
      rel_x     <= rel_x_c;
      rel_y     <= rel_y_c;
      win_type  <= type_c;
      win_frame <= frame_c;
      hsync_d1  <= bus.hsync;
      vsync_d1  <= bus.vsync;
      blank_d1  <= bus.blank;

      // A transparent winner pixel deliberately does not reveal lower-priority objects.
      if (blank_d1)                      bus.p_rgb <= '0;
      else if (bus.char_rgb != 12'h000)  bus.p_rgb <= bus.char_rgb;
      else if (rom_opaque)               bus.p_rgb <= bus.rom_pixel;
      else if (bus.bg_rgb != 12'h000)    bus.p_rgb <= bus.bg_rgb;
      else                               bus.p_rgb <= DEFAULT_RGB;
      bus.hsync_out <= hsync_d1;
      bus.vsync_out <= vsync_d1;
      bus.blank_out <= blank_d1;

      bus.coll_valid <= frame_edge;
      if (frame_edge) begin
        bus.coll_flags <= coll_acc | coll_new;
        coll_acc       <= '0;
      end else begin
        coll_acc       <= coll_acc | coll_new;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_sprite_compositor.sv
// Directed, table-driven bench for sprite_compositor with a small behavioural sprite ROM.
`default_nettype none

module tb_sprite_compositor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sprite_compositor_if #(.N_OBJ(5), .LOG_FRAMES(3)) bus ();

  sprite_compositor dut (
    .vclock (clk),
    .reset  (rst),
    .bus    (bus)
  );

  // ROM: type 1 is fully transparent, others return {1, frame, x, y}.
  assign bus.rom_pixel = (bus.rom_type == 2'd1) ? 12'h000
                                                : {1'b1, bus.rom_frame, bus.rom_x, bus.rom_y};

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic        bl;
    logic [11:0] ch;
    logic [11:0] bg;
    logic        hit;
    logic [3:0]  rx;
    logic [3:0]  ry;
    logic [1:0]  ty;
    logic [2:0]  fr;
    logic [11:0] rgb;
  } vec_t;

  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(int h, int v, bit bl, logic [11:0] ch, logic [11:0] bg, bit hit,
                              int rx, int ry, int ty, int fr, logic [11:0] rgb);
    vec_t t;
    t.h = 11'(h); t.v = 10'(v); t.bl = bl; t.ch = ch; t.bg = bg; t.hit = hit;
    t.rx = 4'(rx); t.ry = 4'(ry); t.ty = 2'(ty); t.fr = 3'(fr); t.rgb = rgb;
    return t;
  endfunction

  function automatic logic [25:0] desc(int fr, int ty, int x, int y);
    return {3'(fr), 2'(ty), 11'(x), 10'(y)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(string tag, vec_t t);
    bus.hcount = t.h; bus.vcount = t.v; bus.blank = t.bl;
    bus.char_rgb = 12'h000; bus.bg_rgb = 12'h000;
    tick();
    chk({tag, " rom_x"}, 32'(bus.rom_x), 32'(t.rx));
    chk({tag, " rom_y"}, 32'(bus.rom_y), 32'(t.ry));
    if (t.hit) begin
      chk({tag, " rom_type"}, 32'(bus.rom_type), 32'(t.ty));
      chk({tag, " rom_frame"}, 32'(bus.rom_frame), 32'(t.fr));
    end
    bus.char_rgb = t.ch; bus.bg_rgb = t.bg;
    tick();
    chk({tag, " p_rgb"}, 32'(bus.p_rgb), 32'(t.rgb));
  endtask

  task automatic frame_pulse(string tag, logic [4:0] exp_flags);
    bus.char_rgb = 12'h000;
    bus.vsync = 1'b0;
    tick();
    chk({tag, " coll_valid"}, 32'(bus.coll_valid), 32'd1);
    chk({tag, " coll_flags"}, 32'(bus.coll_flags), 32'(exp_flags));
    tick();
    chk({tag, " coll_valid_drop"}, 32'(bus.coll_valid), 32'd0);
    bus.vsync = 1'b1;
    tick();
  endtask

  vec_t va[13];
  vec_t vb[5];
  logic [129:0] tab_a, tab_b;

  initial begin
    tab_a = '0;
    tab_a[0*26 +: 26] = desc(2, 0, 100, 200);
    tab_a[2*26 +: 26] = desc(5, 2, 400, 50);
    tab_a[4*26 +: 26] = desc(0, 0, 2040, 1020);
    tab_b = '0;
    tab_b[0*26 +: 26] = desc(3, 1, 300, 300);
    tab_b[1*26 +: 26] = desc(1, 0, 600, 400);
    tab_b[3*26 +: 26] = desc(4, 2, 300, 300);

    va[0]  = mk(100, 200, 0, 12'h000, 12'h000, 1, 0, 0, 0, 2, 12'hA00);
    va[1]  = mk(114, 215, 0, 12'h000, 12'h00F, 1, 14, 15, 0, 2, 12'hAEF);
    va[2]  = mk(115, 200, 0, 12'h000, 12'h00F, 0, 0, 0, 0, 0, 12'h00F);
    va[3]  = mk(99, 200, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 12'hF0F);
    va[4]  = mk(100, 216, 0, 12'h000, 12'h123, 0, 0, 0, 0, 0, 12'h123);
    va[5]  = mk(400, 50, 0, 12'hFA0, 12'h000, 1, 0, 0, 2, 5, 12'hFA0);
    va[6]  = mk(405, 53, 0, 12'h000, 12'h00F, 1, 5, 3, 2, 5, 12'hD53);
    va[7]  = mk(100, 200, 1, 12'hFA0, 12'h00F, 1, 0, 0, 0, 2, 12'h000);
    va[8]  = mk(0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 12'hF0F);
    va[9]  = mk(5, 3, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 12'hF0F);
    va[10] = mk(1023, 767, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 12'hF0F);
    va[11] = mk(1023, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 12'hF0F);
    va[12] = mk(100, 200, 0, 12'h000, 12'h000, 1, 0, 0, 0, 2, 12'hA00);

    vb[0] = mk(300, 300, 0, 12'h000, 12'h00F, 1, 0, 0, 1, 3, 12'h00F);
    vb[1] = mk(100, 200, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 12'hF0F);
    vb[2] = mk(600, 400, 0, 12'h000, 12'h000, 1, 0, 0, 0, 1, 12'h900);
    vb[3] = mk(314, 315, 0, 12'h000, 12'h0F0, 1, 14, 15, 1, 3, 12'h0F0);
    vb[4] = mk(300, 300, 0, 12'hFA0, 12'h000, 1, 0, 0, 1, 3, 12'hFA0);

    rst = 1'b1;
    bus.hcount = '0; bus.vcount = '0; bus.hsync = 1'b1; bus.vsync = 1'b1; bus.blank = 1'b0;
    bus.obj_table = '0; bus.char_rgb = '0; bus.bg_rgb = '0;
    tick(); tick();
    chk("rst p_rgb", 32'(bus.p_rgb), 32'd0);
    chk("rst coll_flags", 32'(bus.coll_flags), 32'd0);
    chk("rst coll_valid", 32'(bus.coll_valid), 32'd0);
    chk("rst syncs", {29'd0, bus.hsync_out, bus.vsync_out, bus.blank_out}, 32'd7);
    chk("rst rom_xy", {24'd0, bus.rom_x, bus.rom_y}, 32'd0);
    rst = 1'b0;
    tick();

    bus.obj_table = tab_a;
    frame_pulse("loadA", 5'b00000);
    for (int i = 0; i < 12; i++) apply($sformatf("A%0d", i), va[i]);
    // Mid-frame table change must not disturb the current frame.
    bus.obj_table = tab_b;
    apply("A12 midframe", va[12]);
    frame_pulse("endA", 5'b00100);

    for (int i = 0; i < 5; i++) apply($sformatf("B%0d", i), vb[i]);
    frame_pulse("endB", 5'b00000);

    // Hit landing on the frame edge itself is reported in the closing frame.
    bus.hcount = 11'd600; bus.vcount = 10'd400; bus.char_rgb = 12'h000;
    tick();
    bus.char_rgb = 12'hFA0; bus.vsync = 1'b0;
    tick();
    chk("edge coll_valid", 32'(bus.coll_valid), 32'd1);
    chk("edge coll_flags", 32'(bus.coll_flags), 32'b00010);
    chk("edge p_rgb", 32'(bus.p_rgb), 32'hFA0);
    bus.char_rgb = 12'h000;
    tick();
    chk("edge coll_valid_drop", 32'(bus.coll_valid), 32'd0);
    bus.vsync = 1'b1;
    tick();

    // Collision, then mid-frame reset.
    bus.hcount = 11'd600; bus.vcount = 10'd400;
    tick();
    bus.char_rgb = 12'hFA0;
    tick();
    chk("prereset p_rgb", 32'(bus.p_rgb), 32'hFA0);
    rst = 1'b1;
    tick();
    chk("midrst p_rgb", 32'(bus.p_rgb), 32'd0);
    chk("midrst syncs", {29'd0, bus.hsync_out, bus.vsync_out, bus.blank_out}, 32'd7);
    rst = 1'b0; bus.char_rgb = 12'h000;
    tick(); tick();
    frame_pulse("postrst", 5'b00000);

    begin
      logic [9:0] hp, vp, bp;
      hp = 10'b1011001011;
      vp = 10'b1110110111;
      bp = 10'b0100110100;
      for (int i = 0; i < 10; i++) begin
        bus.hsync = hp[i]; bus.vsync = vp[i]; bus.blank = bp[i];
        tick();
        if (i >= 1) begin
          chk($sformatf("delay%0d hsync_out", i), 32'(bus.hsync_out), 32'(hp[i-1]));
          chk($sformatf("delay%0d vsync_out", i), 32'(bus.vsync_out), 32'(vp[i-1]));
          chk($sformatf("delay%0d blank_out", i), 32'(bus.blank_out), 32'(bp[i-1]));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
